// File: rtl/booth_seq_multiplier.sv
// Iterative Booth multiplier producing a 2*WIDTH product as hi/lo halves.
// Radix-2 by default; defining BOOTH_RADIX4_EN selects radix-4 modified Booth (fewer iterations).
module booth_seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             signed_mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       fsm_state
);

    // Handshake: start is taken only in IDLE, and the operands and mode are latched on that edge.
    // The hi/lo result is valid from the single done cycle and is held until the next operation
    // completes. abort in RUN returns to IDLE on the next edge without a done pulse.

`ifdef BOOTH_RADIX4_EN
    localparam int EXT_W = WIDTH + 2;
    localparam int ACC_W = EXT_W + 1;
    localparam int STEPS = (WIDTH + 2) / 2;
`else
    localparam int EXT_W = WIDTH + 1;
    localparam int ACC_W = EXT_W;
    localparam int STEPS = WIDTH + 1;
`endif
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [ACC_W-1:0] acc;
    logic [EXT_W-1:0] q_reg;
    logic             q_m1;
    logic [EXT_W-1:0] mcand;
    logic [CNT_W-1:0] cnt;

    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_nxt;
    logic [EXT_W-1:0] q_nxt;
    logic             q_m1_nxt;
    logic [PW-1:0]    product;
    logic             last_step;
    logic             ext_a;
    logic             ext_b;

    assign last_step = (cnt == CNT_W'(STEPS - 1));
    assign ext_a     = signed_mode & multiplicand[WIDTH-1];
    assign ext_b     = signed_mode & multiplier[WIDTH-1];

`ifdef BOOTH_RADIX4_EN
    logic [ACC_W-1:0] m_one;
    logic [ACC_W-1:0] m_two;

    // 2M is a one-bit left shift of the extended multiplicand; the extra accumulator bit absorbs it.
    assign m_one = {mcand[EXT_W-1], mcand};
    assign m_two = {mcand, 1'b0};

    always_comb begin
        sum = acc;
        case ({q_reg[1], q_reg[0], q_m1})
            3'b001, 3'b010: sum = acc + m_one;
            3'b011:         sum = acc + m_two;
            3'b100:         sum = acc - m_two;
            3'b101, 3'b110: sum = acc - m_one;
            default:        sum = acc;
        endcase
        acc_nxt  = {{2{sum[ACC_W-1]}}, sum[ACC_W-1:2]};
        q_nxt    = {sum[1:0], q_reg[EXT_W-1:2]};
        q_m1_nxt = q_reg[1];
    end
`else
    always_comb begin
        sum = acc;
        case ({q_reg[0], q_m1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        acc_nxt  = {sum[ACC_W-1], sum[ACC_W-1:1]};
        q_nxt    = {sum[0], q_reg[EXT_W-1:1]};
        q_m1_nxt = q_reg[0];
    end
`endif

    // Extension makes the upper product bits redundant; only the low 2*WIDTH are kept.
    assign product = PW'({acc_nxt, q_nxt});

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign fsm_state = state_q;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            acc   <= '0;
            q_reg <= '0;
            q_m1  <= 1'b0;
            mcand <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (state_q == IDLE && start) begin
                acc   <= '0;
                q_reg <= {{(EXT_W - WIDTH){ext_b}}, multiplier};
                q_m1  <= 1'b0;
                mcand <= {{(EXT_W - WIDTH){ext_a}}, multiplicand};
                cnt   <= '0;
            end else if (state_q == RUN && !abort) begin
                acc   <= acc_nxt;
                q_reg <= q_nxt;
                q_m1  <= q_m1_nxt;
                cnt   <= cnt + CNT_W'(1);
                if (last_step) begin
                    hi <= product[PW-1:WIDTH];
                    lo <= product[WIDTH-1:0];
                end
            end
        end
    end

endmodule
